// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard/forwarding control bundle between the pipeline datapath (master) and
// pipe_hazard_ctrl (slave).
interface pipe_hazard_ctrl_if #(
   parameter int unsigned AW     = 5,
   parameter int unsigned PERF_W = 32
);
   logic [AW-1:0]     id_rs;
   logic [AW-1:0]     id_rt;
   logic              id_uses_rs;
   logic              id_uses_rt;
   logic              id_mdu_start;
   logic              id_mdu_read;
   logic [AW-1:0]     ex_rs;
   logic [AW-1:0]     ex_rt;
   logic [AW-1:0]     ex_rd;
   logic              ex_mem_read;
   logic              ex_branch_taken;
   logic [AW-1:0]     mem_rd;
   logic [AW-1:0]     wb_rd;
   logic              mem_reg_write;
   logic              wb_reg_write;
   logic [1:0]        forward_a;
   logic [1:0]        forward_b;
   logic              stall;
   logic              bubble_idex;
   logic              flush_ifid;
   logic              mdu_busy;
   logic [PERF_W-1:0] perf_stall_cnt;
   logic [PERF_W-1:0] perf_flush_cnt;

   modport master (
      output id_rs, id_rt, id_uses_rs, id_uses_rt, id_mdu_start, id_mdu_read,
      output ex_rs, ex_rt, ex_rd, ex_mem_read, ex_branch_taken,
      output mem_rd, wb_rd, mem_reg_write, wb_reg_write,
      input  forward_a, forward_b, stall, bubble_idex, flush_ifid, mdu_busy,
      input  perf_stall_cnt, perf_flush_cnt
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_mdu_start, id_mdu_read,
      input  ex_rs, ex_rt, ex_rd, ex_mem_read, ex_branch_taken,
      input  mem_rd, wb_rd, mem_reg_write, wb_reg_write,
      output forward_a, forward_b, stall, bubble_idex, flush_ifid, mdu_busy,
      output perf_stall_cnt, perf_flush_cnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// EX forwarding, load-use stall sequencer, MDU HI/LO interlock and branch flush control.
// Optional stall/flush performance counters are built when HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl #(
   parameter int unsigned AW         = 5,
   parameter int unsigned LOAD_STALL = 1,
   parameter int unsigned MDU_LAT    = 4,
   parameter int unsigned PERF_W     = 32
) (
   input logic           clk,
   input logic           reset_n,
   pipe_hazard_ctrl_if.slave hz
);

   typedef enum logic [0:0] {StIdle, StLwait} state_e;

   localparam logic [2:0] LoadWait = 3'(LOAD_STALL - 1);
   localparam logic [5:0] MduLat   = 6'(MDU_LAT);

   state_e     state_q;
   logic [2:0] lcnt_q;
   logic [5:0] mcnt_q;
   logic       mdu_busy_q;

   logic       load_hit;
   logic       mdu_hit;
   logic       stall;
   logic       mdu_issue;
   logic       branch;

   // MEM result is newer than WB, so it wins when both match.
   function automatic logic [1:0] fwd_sel(input logic [AW-1:0] src,
                                          input logic          mem_we,
                                          input logic [AW-1:0] mem_rd,
                                          input logic          wb_we,
                                          input logic [AW-1:0] wb_rd);
      logic [1:0] sel;
      sel = 2'b00;
      if (mem_we && (mem_rd != '0) && (mem_rd == src)) begin
         sel = 2'b10;
      end else if (wb_we && (wb_rd != '0) && (wb_rd == src)) begin
         sel = 2'b01;
      end
      return sel;
   endfunction

   always_comb begin
      hz.forward_a = fwd_sel(hz.ex_rs, hz.mem_reg_write, hz.mem_rd, hz.wb_reg_write, hz.wb_rd);
      hz.forward_b = fwd_sel(hz.ex_rt, hz.mem_reg_write, hz.mem_rd, hz.wb_reg_write, hz.wb_rd);
   end

   always_comb begin
      branch   = hz.ex_branch_taken;
      load_hit = hz.ex_mem_read && (hz.ex_rd != '0) &&
                 ((hz.id_uses_rs && (hz.ex_rd == hz.id_rs)) ||
                  (hz.id_uses_rt && (hz.ex_rd == hz.id_rt)));
      mdu_hit  = (hz.id_mdu_start || hz.id_mdu_read) && mdu_busy_q;
      // A taken branch kills whatever is in IF/ID, so holding it is pointless.
      stall    = !branch && ((state_q == StLwait) || load_hit || mdu_hit);
      mdu_issue = hz.id_mdu_start && !stall && !branch;
   end

   assign hz.stall       = stall;
   assign hz.bubble_idex = stall || branch;
   assign hz.flush_ifid  = branch;
   assign hz.mdu_busy    = mdu_busy_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         lcnt_q     <= 3'd0;
         mcnt_q     <= 6'd0;
         mdu_busy_q <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (load_hit && !branch && (LOAD_STALL > 1)) begin
                  state_q <= StLwait;
                  lcnt_q  <= LoadWait;
               end
            end
            StLwait: begin
               if (branch || (lcnt_q == 3'd1)) begin
                  state_q <= StIdle;
                  lcnt_q  <= 3'd0;
               end else begin
                  lcnt_q <= lcnt_q - 3'd1;
               end
            end
            default: begin
               state_q <= StIdle;
               lcnt_q  <= 3'd0;
            end
         endcase

         // An in-flight operation keeps counting through flushes.
         if (mdu_issue) begin
            mcnt_q     <= MduLat;
            mdu_busy_q <= (MduLat != 6'd0);
         end else if (mcnt_q != 6'd0) begin
            mcnt_q     <= mcnt_q - 6'd1;
            mdu_busy_q <= (mcnt_q != 6'd1);
         end
      end
   end

`ifdef HAZARD_PERF_EN
   logic [PERF_W-1:0] perf_stall_q;
   logic [PERF_W-1:0] perf_flush_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_stall_q <= '0;
         perf_flush_q <= '0;
      end else begin
         if (stall) begin
            perf_stall_q <= perf_stall_q + 1'b1;
         end
         if (branch) begin
            perf_flush_q <= perf_flush_q + 1'b1;
         end
      end
   end

   assign hz.perf_stall_cnt = perf_stall_q;
   assign hz.perf_flush_cnt = perf_flush_q;
`else
   assign hz.perf_stall_cnt = {PERF_W{1'b0}};
   assign hz.perf_flush_cnt = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: one instance with LOAD_STALL=1, one with
// LOAD_STALL=3, driven by the same stimulus; tables, corner sequences and a random run.
module tb_pipe_hazard_ctrl;

   localparam int MduLat = 4;
`ifdef HAZARD_PERF_EN
   localparam bit PerfOn = 1'b1;
`else
   localparam bit PerfOn = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
   logic id_uses_rs, id_uses_rt, id_mdu_start, id_mdu_read;
   logic ex_mem_read, ex_branch_taken, mem_reg_write, wb_reg_write;

   logic [1:0]  fa  [2];
   logic [1:0]  fb  [2];
   logic        st  [2];
   logic        bub [2];
   logic        fl  [2];
   logic        busy[2];
   logic [31:0] pst [2];
   logic [31:0] pfl [2];

   pipe_hazard_ctrl_if #(.AW(5), .PERF_W(32)) hz[2] ();

   for (genvar g = 0; g < 2; g++) begin : g_conn
      assign hz[g].id_rs           = id_rs;
      assign hz[g].id_rt           = id_rt;
      assign hz[g].id_uses_rs      = id_uses_rs;
      assign hz[g].id_uses_rt      = id_uses_rt;
      assign hz[g].id_mdu_start    = id_mdu_start;
      assign hz[g].id_mdu_read     = id_mdu_read;
      assign hz[g].ex_rs           = ex_rs;
      assign hz[g].ex_rt           = ex_rt;
      assign hz[g].ex_rd           = ex_rd;
      assign hz[g].ex_mem_read     = ex_mem_read;
      assign hz[g].ex_branch_taken = ex_branch_taken;
      assign hz[g].mem_rd          = mem_rd;
      assign hz[g].wb_rd           = wb_rd;
      assign hz[g].mem_reg_write   = mem_reg_write;
      assign hz[g].wb_reg_write    = wb_reg_write;
      assign fa[g]   = hz[g].forward_a;
      assign fb[g]   = hz[g].forward_b;
      assign st[g]   = hz[g].stall;
      assign bub[g]  = hz[g].bubble_idex;
      assign fl[g]   = hz[g].flush_ifid;
      assign busy[g] = hz[g].mdu_busy;
      assign pst[g]  = hz[g].perf_stall_cnt;
      assign pfl[g]  = hz[g].perf_flush_cnt;
   end

   pipe_hazard_ctrl #(.AW(5), .LOAD_STALL(1), .MDU_LAT(MduLat), .PERF_W(32)) u_dut1 (
      .clk     (clk),
      .reset_n (reset_n),
      .hz      (hz[0])
   );

   pipe_hazard_ctrl #(.AW(5), .LOAD_STALL(3), .MDU_LAT(MduLat), .PERF_W(32)) u_dut3 (
      .clk     (clk),
      .reset_n (reset_n),
      .hz      (hz[1])
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic clear_in();
      id_rs = '0; id_rt = '0; ex_rs = '0; ex_rt = '0; ex_rd = '0; mem_rd = '0; wb_rd = '0;
      id_uses_rs = 0; id_uses_rt = 0; id_mdu_start = 0; id_mdu_read = 0;
      ex_mem_read = 0; ex_branch_taken = 0; mem_reg_write = 0; wb_reg_write = 0;
   endtask

   // Inputs change 1 time unit after the rising edge; checks happen 3 units later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic set_load8();
      ex_mem_read = 1; ex_rd = 5'd8; id_rs = 5'd8; id_uses_rs = 1;
   endtask

   typedef struct {
      logic [4:0] mrd, wrd;
      logic       mwe, wwe;
      logic [4:0] rs, rt;
      logic [1:0] ea, eb;
   } fwd_vec_t;

   // Behavioural reference state: cycle numbers at which each condition ends.
   int cyc;
   int lw_end[2];
   int md_end[2];
   int m_pst[2];
   int m_pfl[2];

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         lw_end[k] = cyc - 1;
         md_end[k] = cyc - 1;
         m_pst[k]  = 0;
         m_pfl[k]  = 0;
      end
   endtask

   function automatic logic [1:0] ref_fwd(input logic [4:0] src);
      if (mem_reg_write && mem_rd != 0 && mem_rd == src) return 2'b10;
      if (wb_reg_write && wb_rd != 0 && wb_rd == src) return 2'b01;
      return 2'b00;
   endfunction

   initial begin
      fwd_vec_t vecs[9];
      vecs[0] = '{5'd5,  5'd5,  1, 1, 5'd5,  5'd5,  2'b10, 2'b10};
      vecs[1] = '{5'd5,  5'd5,  0, 1, 5'd5,  5'd5,  2'b01, 2'b01};
      vecs[2] = '{5'd0,  5'd0,  1, 1, 5'd0,  5'd0,  2'b00, 2'b00};
      vecs[3] = '{5'd5,  5'd7,  1, 1, 5'd7,  5'd5,  2'b01, 2'b10};
      vecs[4] = '{5'd5,  5'd7,  1, 0, 5'd7,  5'd5,  2'b00, 2'b10};
      vecs[5] = '{5'd3,  5'd3,  0, 0, 5'd3,  5'd3,  2'b00, 2'b00};
      vecs[6] = '{5'd9,  5'd9,  1, 1, 5'd9,  5'd4,  2'b10, 2'b00};
      vecs[7] = '{5'd0,  5'd9,  1, 1, 5'd0,  5'd9,  2'b00, 2'b01};
      vecs[8] = '{5'd31, 5'd31, 1, 1, 5'd31, 5'd31, 2'b10, 2'b10};

      cyc = 0;
      clear_in();
      reset_n = 0;
      #3;
      for (int k = 0; k < 2; k++) begin
         chk("reset_stall", 32'(st[k]), 0);
         chk("reset_busy", 32'(busy[k]), 0);
         chk("reset_fwd_a", 32'(fa[k]), 0);
         chk("reset_perf_stall", pst[k], 0);
         chk("reset_perf_flush", pfl[k], 0);
      end
      // Combinational outputs must follow inputs while reset is held.
      set_load8();
      #1;
      for (int k = 0; k < 2; k++) chk("reset_comb_stall", 32'(st[k]), 1);
      clear_in();
      tick();
      reset_n = 1;

      // Forwarding table
      for (int i = 0; i < 9; i++) begin
         mem_rd = vecs[i].mrd; wb_rd = vecs[i].wrd;
         mem_reg_write = vecs[i].mwe; wb_reg_write = vecs[i].wwe;
         ex_rs = vecs[i].rs; ex_rt = vecs[i].rt;
         #1;
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("fwd_a[%0d]", i), 32'(fa[k]), 32'(vecs[i].ea));
            chk($sformatf("fwd_b[%0d]", i), 32'(fb[k]), 32'(vecs[i].eb));
         end
      end

      // Load-use: 1 cycle on u_dut1, 3 cycles on u_dut3
      clear_in();
      tick();
      set_load8();
      settle();
      for (int k = 0; k < 2; k++) begin
         chk("lu_c0_stall", 32'(st[k]), 1);
         chk("lu_c0_bubble", 32'(bub[k]), 1);
         chk("lu_c0_flush", 32'(fl[k]), 0);
      end
      tick();
      ex_mem_read = 0; ex_rd = 0; mem_rd = 5'd8; mem_reg_write = 1; ex_rs = 5'd8;
      settle();
      chk("lu1_c1_stall", 32'(st[0]), 0);
      chk("lu1_c1_fwd_a", 32'(fa[0]), 32'(2'b10));
      chk("lu3_c1_stall", 32'(st[1]), 1);
      tick();
      settle();
      chk("lu3_c2_stall", 32'(st[1]), 1);
      chk("lu3_c2_bubble", 32'(bub[1]), 1);
      tick();
      settle();
      chk("lu3_c3_stall", 32'(st[1]), 0);
      chk("lu3_c3_bubble", 32'(bub[1]), 0);

      // Load-use cancelled by a taken branch in the second stall cycle
      clear_in();
      tick();
      set_load8();
      settle();
      chk("lub_c0_stall", 32'(st[1]), 1);
      tick();
      clear_in();
      ex_branch_taken = 1;
      settle();
      for (int k = 0; k < 2; k++) begin
         chk("lub_c1_stall", 32'(st[k]), 0);
         chk("lub_c1_flush", 32'(fl[k]), 1);
         chk("lub_c1_bubble", 32'(bub[k]), 1);
      end
      tick();
      ex_branch_taken = 0;
      settle();
      chk("lub_c2_stall", 32'(st[1]), 0);

      // mult at t, mfhi waiting from t+1
      clear_in();
      tick();
      id_mdu_start = 1;
      settle();
      for (int k = 0; k < 2; k++) begin
         chk("mdu_t_stall", 32'(st[k]), 0);
         chk("mdu_t_busy", 32'(busy[k]), 0);
      end
      tick();
      id_mdu_start = 0; id_mdu_read = 1;
      for (int c = 1; c <= MduLat; c++) begin
         settle();
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("mdu_t%0d_busy", c), 32'(busy[k]), 1);
            chk($sformatf("mdu_t%0d_stall", c), 32'(st[k]), 1);
         end
         tick();
      end
      settle();
      for (int k = 0; k < 2; k++) begin
         chk("mdu_done_busy", 32'(busy[k]), 0);
         chk("mdu_done_stall", 32'(st[k]), 0);
      end

      // mult discarded by a taken branch
      clear_in();
      tick();
      id_mdu_start = 1; ex_branch_taken = 1;
      settle();
      chk("mdub_flush", 32'(fl[0]), 1);
      tick();
      clear_in();
      settle();
      for (int k = 0; k < 2; k++) chk("mdub_busy", 32'(busy[k]), 0);

      // Reset during LWAIT and MDU busy
      tick();
      id_mdu_start = 1;
      tick();
      id_mdu_start = 0;
      set_load8();
      tick();
      clear_in();
      settle();
      chk("rst_pre_stall", 32'(st[1]), 1);
      chk("rst_pre_busy", 32'(busy[1]), 1);
      reset_n = 0;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("rst_mid_stall", 32'(st[k]), 0);
         chk("rst_mid_busy", 32'(busy[k]), 0);
      end
      tick();
      reset_n = 1;
      settle();
      for (int k = 0; k < 2; k++) chk("rst_post_stall", 32'(st[k]), 0);

      // 5 stall cycles then 2 flushes
      tick();
      set_load8();
      repeat (5) tick();
      clear_in();
      ex_branch_taken = 1;
      repeat (2) tick();
      ex_branch_taken = 0;
      settle();
      for (int k = 0; k < 2; k++) begin
         chk("perf_stall", pst[k], PerfOn ? 32'd5 : 32'd0);
         chk("perf_flush", pfl[k], PerfOn ? 32'd2 : 32'd0);
      end

      // Randomised run against the reference model
      tick();
      reset_n = 0;
      #1;
      reset_n = 1;
      model_reset();
      for (int n = 0; n < 2000; n++) begin
         tick();
         cyc++;
         id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
         ex_rs = 5'($urandom_range(0, 3)); ex_rt = 5'($urandom_range(0, 3));
         ex_rd = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
         wb_rd = 5'($urandom_range(0, 3));
         id_uses_rs = 1'($urandom_range(0, 1)); id_uses_rt = 1'($urandom_range(0, 1));
         id_mdu_start = ($urandom_range(0, 3) == 0); id_mdu_read = ($urandom_range(0, 3) == 0);
         ex_mem_read = ($urandom_range(0, 2) == 0); ex_branch_taken = ($urandom_range(0, 7) == 0);
         mem_reg_write = 1'($urandom_range(0, 1)); wb_reg_write = 1'($urandom_range(0, 1));
         settle();
         for (int k = 0; k < 2; k++) begin
            int  lat;
            bit  in_lw, busy_m, lh, mh, st_m;
            lat    = (k == 0) ? 1 : 3;
            in_lw  = (cyc <= lw_end[k]);
            busy_m = (cyc <= md_end[k]);
            lh = ex_mem_read && ex_rd != 0 &&
                 ((id_uses_rs && ex_rd == id_rs) || (id_uses_rt && ex_rd == id_rt));
            mh = (id_mdu_start || id_mdu_read) && busy_m;
            st_m = !ex_branch_taken && (in_lw || lh || mh);
            chk("rnd_fwd_a", 32'(fa[k]), 32'(ref_fwd(ex_rs)));
            chk("rnd_fwd_b", 32'(fb[k]), 32'(ref_fwd(ex_rt)));
            chk("rnd_stall", 32'(st[k]), 32'(st_m));
            chk("rnd_bubble", 32'(bub[k]), 32'(st_m || ex_branch_taken));
            chk("rnd_flush", 32'(fl[k]), 32'(ex_branch_taken));
            chk("rnd_busy", 32'(busy[k]), 32'(busy_m));
            chk("rnd_perf_stall", pst[k], PerfOn ? 32'(m_pst[k]) : 32'd0);
            chk("rnd_perf_flush", pfl[k], PerfOn ? 32'(m_pfl[k]) : 32'd0);
            if (ex_branch_taken) lw_end[k] = cyc;
            else if (!in_lw && lh) lw_end[k] = cyc + lat - 1;
            if (id_mdu_start && !st_m && !ex_branch_taken) md_end[k] = cyc + MduLat;
            m_pst[k] += int'(st_m);
            m_pfl[k] += int'(ex_branch_taken);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Second-generation hazard and forwarding controller for the 5-stage MIPS pipeline. It decides EX-stage operand forwarding, the same as the previous unit, with a parametrised register-address width. It adds a registered load-use stall sequencer with configurable load latency, a multi-cycle MDU (mul/div) busy tracker with HI/LO interlock, and branch-taken flush control. It sits beside the IF/ID and ID/EX pipeline registers and drives their hold and clear controls.

Parameters:
AW, 5, register address width; register 0 is the hard-wired zero register and is never forwarded or interlocked.
LOAD_STALL, 1, total stall cycles for a load-use hazard (legal range 1..7).
MDU_LAT, 4, MDU execution cycles after issue (legal range 1..63).
PERF_W, 32, width of the performance counters (optional feature only).

Ports:
clk  in  1  pipeline clock
reset_n  in  1  asynchronous active-low reset
id_rs, id_rt  in  AW  source registers of the ID instruction
id_uses_rs, id_uses_rt  in  1  ID instruction actually reads rs / rt
id_mdu_start  in  1  ID instruction is mult/div
id_mdu_read  in  1  ID instruction is mfhi/mflo
ex_rs, ex_rt  in  AW  source registers of the EX instruction
ex_rd  in  AW  destination of the EX instruction (after RegDst mux)
ex_mem_read  in  1  EX instruction is a load
ex_branch_taken  in  1  branch/jump resolved taken in EX
mem_rd, wb_rd  in  AW  destinations in MEM / WB
mem_reg_write, wb_reg_write  in  1  register write enables in MEM / WB
forward_a, forward_b  out  2  00 = register file, 10 = MEM result, 01 = WB result
stall  out  1  hold PC and IF/ID
bubble_idex  out  1  clear ID/EX (insert NOP)
flush_ifid  out  1  clear IF/ID
mdu_busy  out  1  MDU operation in flight
perf_stall_cnt  out  PERF_W  stall cycle count
perf_flush_cnt  out  PERF_W  flush event count

Behaviour:
- Forwarding is combinational. forward_a = 10 if mem_reg_write, mem_rd!=0 and mem_rd==ex_rs. Otherwise it is 01 if wb_reg_write, wb_rd!=0 and wb_rd==ex_rs. Otherwise it is 00. forward_b follows the same rules against ex_rt. MEM always has priority over WB.
- load_hit = ex_mem_read & ex_rd!=0 & ((id_uses_rs & ex_rd==id_rs) | (id_uses_rt & ex_rd==id_rt)).
- mdu_hit = (id_mdu_start | id_mdu_read) & mdu_busy.
- FSM states:
  - IDLE: stall = load_hit | mdu_hit. If load_hit, ex_branch_taken is low and LOAD_STALL>1, go to LWAIT and load lcnt with LOAD_STALL-1.
  - LWAIT: stall = 1. lcnt decrements each cycle. Return to IDLE on the cycle lcnt is 1, so total stall for one load-use is exactly LOAD_STALL cycles.
- MDU counter mcnt, 6 bits:
  - Loaded with MDU_LAT on the clock edge where id_mdu_start=1, stall=0 and ex_branch_taken=0.
  - Otherwise decrements while nonzero.
  - mdu_busy = (mcnt!=0), registered.
  - A start held by stall issues on the first cycle stall drops.
- Flush:
  - ex_branch_taken=1 forces stall=0, flush_ifid=1 and bubble_idex=1 in the same cycle.
  - FSM is forced to IDLE on the next edge (LWAIT cancelled).
  - An MDU start presented in ID that cycle is discarded. An in-flight MDU operation continues.
- bubble_idex = stall | ex_branch_taken.
- Simultaneous load_hit and mdu_hit: one stall; each condition is released independently. stall remains 1 until both clear.
- Reset (asynchronous, on reset_n low): FSM=IDLE, lcnt=0, mcnt=0, mdu_busy=0, perf counters 0. Combinational outputs follow the inputs immediately.
- Reset asserted mid-LWAIT or mid-MDU aborts both with no residual stall.

Optional Feature:
HAZARD_PERF_EN.
- Defined: perf_stall_cnt increments on every cycle with stall=1. perf_flush_cnt increments on every cycle with ex_branch_taken=1. Both counters wrap at 2^PERF_W and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- LOAD_STALL=1, lw $8 in EX (ex_mem_read=1, ex_rd=8), ID uses rs=8 -> stall=1 and bubble_idex=1 for exactly 1 cycle, FSM stays IDLE; next cycle forward_a=10 if the load moved to MEM.
- LOAD_STALL=3, same hazard -> stall high for 3 consecutive cycles, then 0; ex_branch_taken in the 2nd cycle -> stall=0 and flush_ifid=1 that cycle, FSM IDLE next.
- mem_rd=wb_rd=5 with both write enables 1, ex_rs=5 -> forward_a=10; drop mem_reg_write -> 01; set ex_rs=0 with mem_rd=0 -> 00.
- MDU_LAT=4, mult issues at cycle t, mfhi arrives in ID at t+1 -> mdu_busy 1 for cycles t+1..t+4, stall 1 while busy, mfhi released when mdu_busy falls.
- mult in ID with ex_branch_taken=1 -> mdu_busy stays 0.
- reset_n pulsed low during LWAIT and an MDU busy period -> stall=0 and mdu_busy=0 immediately; with HAZARD_PERF_EN, 5 stall cycles and 2 flushes -> perf_stall_cnt=5, perf_flush_cnt=2.
